fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-byte prefetch queue upstream of the cpu core's st_new_op/operand states.
//  Reads sequential bytes from synchronous memory (1-cycle read latency) and buffers them.
//  Hands opcode/operand bytes to the core with a VALID/POP handshake.
//  LOAD flushes the queue and restarts fetching at a new address (jump/branch/reset vector).
// PARAMETERS
//  DEPTH     4        queue entries (power of 2, >=2)
//  RESET_PC  16'h0000 fetch and head address after reset
// PORTS
//  CLK        in   1   clock, all state updates on posedge
//  R          in   1   synchronous active-high reset
//  LOAD       in   1   flush queue, restart fetch at LOAD_ADDR
//  LOAD_ADDR  in   16  new fetch address
//  POP        in   1   consumer takes head byte (honoured only when VALID)
//  DATA_OUT   out  8   head byte
//  DATA_PC    out  16  address of head byte
//  VALID      out  1   queue non-empty
//  COUNT      out  3   bytes held (0..DEPTH)
//  MEM_ADDR   out  16  memory read address (= fetch_pc)
//  MEM_RD     out  1   read issued this cycle
//  MEM_DATA   in   8   read data, valid the cycle after MEM_RD
// BEHAVIOUR
//  Reset (R high at edge): fetch_pc=head_pc=RESET_PC, COUNT=0, VALID=0, in-flight cleared;
//   DATA_OUT=8'h00. R overrides LOAD and POP.
//  State: fetch_pc, head_pc, circular buffer rd/wr ptrs, count, inflight flag.
//  Issue: MEM_RD = !R && !LOAD && (count + inflight < DEPTH); combinational.
//   On issue: fetch_pc <= fetch_pc+1 (16-bit wrap FFFF->0000), inflight <= 1; else inflight <= 0.
//  Return: if inflight at an edge and no LOAD that cycle, MEM_DATA is written at wr_ptr.
//   inflight never exceeds 1; reads may issue every cycle (pipelined).
//  POP with VALID: rd_ptr++, head_pc++ (wrap). POP with VALID=0: ignored, no state change.
//  Simultaneous return and POP: both happen, COUNT unchanged.
//  Credit check uses count before POP (conservative). The queue never overflows.
//  LOAD (edge, not R): count<=0, ptrs<=0, head_pc<=fetch_pc<=LOAD_ADDR, inflight<=0.
//   Any return due that cycle is discarded. POP in the same cycle is ignored.
//  LOAD latency: LOAD edge E0 -> MEM_RD=1 with MEM_ADDR=LOAD_ADDR after E0.
//   Byte captured at E2; VALID=1, DATA_PC=LOAD_ADDR after E2.
//  Steady state with POP every cycle: one byte per cycle after the initial 2-cycle fill.
//  DATA_OUT/DATA_PC are valid only while VALID=1. DATA_OUT content is don't-care when VALID=0.
//  The memory read port is read-only; there is no write path.
// TESTING
//  1 Reset, mem[i]=i^8'hA5, no POP.
//    -> MEM_RD at 0000..0003, then MEM_RD=0.
//    -> COUNT=4, DATA_OUT=A5, DATA_PC=0000; COUNT never exceeds 4.
//  2 LOAD 0x1234, POP every cycle while VALID.
//    -> VALID 2 edges after LOAD; bytes mem[1234],mem[1235],... one per cycle in order.
//    -> DATA_PC tracks the address of each byte.
//  3 Full queue; assert LOAD 0x4000 on the same edge a return is due.
//    -> returned byte discarded, COUNT=0.
//    -> first VALID byte is mem[4000] with DATA_PC=4000.
//  4 LOAD 0xFFFE, no POP.
//    -> MEM_ADDR FFFE,FFFF,0000,0001.
//    -> popping yields DATA_PC FFFE,FFFF,0000,0001 with matching data.
//  5 POP held high while VALID=0 after reset; also POP+LOAD on the same edge.
//    -> no underflow, COUNT stays 0, LOAD wins.
//  6 R asserted mid-stream with COUNT=3 and a read in flight.
//    -> next edge COUNT=0, VALID=0, fetch_pc=RESET_PC.
//    -> the in-flight byte is never enqueued.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
// ----------------------------------------------------------------------------
// Instruction-byte prefetch queue. It reads sequential bytes from a
// synchronous memory with a 1-cycle read latency. It buffers up to DEPTH bytes
// and hands them to the core through a VALID/POP handshake. LOAD flushes the
// queue and restarts fetching at LOAD_ADDR.
//
// Ports
//   CLK        in   1   clock, all state updates on posedge
//   R          in   1   synchronous active-high reset (overrides LOAD/POP)
//   LOAD       in   1   flush queue, restart fetch at LOAD_ADDR
//   LOAD_ADDR  in   16  new fetch address
//   POP        in   1   consumer takes head byte (honoured only when VALID)
//   DATA_OUT   out  8   head byte (8'h00 while VALID=0)
//   DATA_PC    out  16  address of head byte
//   VALID      out  1   queue non-empty
//   COUNT      out  3   bytes held (0..DEPTH)
//   MEM_ADDR   out  16  memory read address (current fetch pc)
//   MEM_RD     out  1   read issued this cycle
//   MEM_DATA   in   8   read data, valid the cycle after MEM_RD
// ============================================================================
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     CLK,
    input  logic                     R,
    input  logic                     LOAD,
    input  logic [15:0]              LOAD_ADDR,
    input  logic                     POP,
    output logic [7:0]               DATA_OUT,
    output logic [15:0]              DATA_PC,
    output logic                     VALID,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [15:0]              MEM_ADDR,
    output logic                     MEM_RD,
    input  logic [7:0]               MEM_DATA
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   head_pc_q,  head_pc_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          inflight_q, inflight_d;
    logic [7:0]    mem_q [DEPTH];

    logic [CW:0]   credit_used;
    logic          issue;
    logic          ret;
    logic          pop_ok;

    // Credit counts the outstanding read as occupied. It uses the count before
    // any POP on this edge, so the queue can never overflow.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue       = !R && !LOAD && (credit_used < DEPTH_W);
    assign ret         = inflight_q && !LOAD;
    assign pop_ok      = POP && (count_q != '0) && !LOAD;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = 1'b0;
        if (LOAD) begin
            // The return due this cycle and any POP are both dropped.
            fetch_pc_d = LOAD_ADDR;
            head_pc_d  = LOAD_ADDR;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 16'd1;
                inflight_d = 1'b1;
            end
            if (ret) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                head_pc_d = head_pc_q + 16'd1;
            end
            case ({ret, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // The storage array is left unreset. DATA_OUT is gated while empty, so
    // stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (!R && ret) begin
            mem_q[wr_ptr_q] <= MEM_DATA;
        end
    end

    assign VALID    = (count_q != '0);
    assign COUNT    = count_q;
    assign DATA_OUT = VALID ? mem_q[rd_ptr_q] : '0;
    assign DATA_PC  = head_pc_q;
    assign MEM_ADDR = fetch_pc_q;
    assign MEM_RD   = issue;

endmodule

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue
// ----------------------------------------------------------------------------
// Randomised and directed bench for fetch_queue. The reference model is a
// queue of byte addresses. Expected data is the memory content function
// evaluated at each address.
// ============================================================================
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        CLK = 1'b0;
    logic        R = 1'b1;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_ADDR = '0;
    logic        POP = 1'b0;
    logic [7:0]  DATA_OUT;
    logic [15:0] DATA_PC;
    logic        VALID;
    logic [2:0]  COUNT;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic [7:0]  MEM_DATA = '0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK       (CLK),
        .R         (R),
        .LOAD      (LOAD),
        .LOAD_ADDR (LOAD_ADDR),
        .POP       (POP),
        .DATA_OUT  (DATA_OUT),
        .DATA_PC   (DATA_PC),
        .VALID     (VALID),
        .COUNT     (COUNT),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_RD    (MEM_RD),
        .MEM_DATA  (MEM_DATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] memval(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Synchronous read memory. Idle cycles return noise, so a spurious write
    // into the queue would be caught.
    always @(posedge CLK) begin
        if (MEM_RD) MEM_DATA <= memval(MEM_ADDR);
        else        MEM_DATA <= 8'($urandom);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [15:0] mq[$];
    int          pend = 0;
    logic [15:0] pend_addr = '0;
    logic [15:0] fetch = RESET_PC;

    task automatic model_step(input logic r, input logic ld,
                              input logic [15:0] la, input logic pop);
        bit can_issue;
        if (r) begin
            mq.delete();
            pend  = 0;
            fetch = RESET_PC;
        end else if (ld) begin
            mq.delete();
            pend  = 0;
            fetch = la;
        end else begin
            can_issue = (mq.size() + pend) < DEPTH;
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (pend != 0) mq.push_back(pend_addr);
            pend = can_issue ? 1 : 0;
            if (can_issue) begin
                pend_addr = fetch;
                fetch     = fetch + 16'd1;
            end
        end
    endtask

    task automatic check_state();
        check_eq("count", COUNT, mq.size());
        check_eq("valid", VALID, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("data_pc", DATA_PC, mq[0]);
            check_eq("data_out", DATA_OUT, memval(mq[0]));
        end
    endtask

    // Inputs are applied 1 time unit after a posedge. Combinational outputs
    // are checked before the next edge, and registered outputs 1 unit after it.
    task automatic cycle(input logic r, input logic ld,
                         input logic [15:0] la, input logic pop);
        bit exp_rd;
        R = r; LOAD = ld; LOAD_ADDR = la; POP = pop;
        #1;
        exp_rd = !r && !ld && ((mq.size() + pend) < DEPTH);
        check_eq("mem_rd", MEM_RD, exp_rd);
        if (exp_rd) check_eq("mem_addr", MEM_ADDR, fetch);
        @(posedge CLK);
        model_step(r, ld, la, pop);
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, mq.size() != 0);
    endtask

    initial begin
        // Reset. POP is held high while the queue is empty.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check_eq("rst_data_out", DATA_OUT, 8'h00);
        check_eq("rst_valid", VALID, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("pop_empty_count", COUNT, 3'd0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Fill from reset: reads at 0000..0003, then the queue is full.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        idle(8);
        check_eq("fill_count", COUNT, 3'd4);
        check_eq("fill_data", DATA_OUT, 8'hA5);
        check_eq("fill_pc", DATA_PC, 16'h0000);
        check_eq("fill_no_rd", MEM_RD, 1'b0);

        // POP and LOAD on the same edge: LOAD wins.
        cycle(1'b0, 1'b1, 16'h2000, 1'b1);
        check_eq("popload_count", COUNT, 3'd0);

        // LOAD 1234, then stream with POP while VALID.
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(2);
        check_eq("load_valid_e2", VALID, 1'b1);
        check_eq("load_pc_e2", DATA_PC, 16'h1234);
        pops(12);

        // Full queue; LOAD lands on the edge where a return is due.
        idle(6);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        idle(1);
        check_eq("pre_load_count", COUNT, 3'd3);
        cycle(1'b0, 1'b1, 16'h4000, 1'b0);
        check_eq("load_drop_count", COUNT, 3'd0);
        idle(3);
        check_eq("load4000_pc", DATA_PC, 16'h4000);
        check_eq("load4000_data", DATA_OUT, memval(16'h4000));

        // Address wrap FFFE..0001.
        cycle(1'b0, 1'b1, 16'hFFFE, 1'b0);
        idle(6);
        pops(5);

        // Reset while COUNT=3 and a read is in flight.
        idle(6);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        idle(1);
        check_eq("pre_rst_count", COUNT, 3'd3);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check_eq("mid_rst_count", COUNT, 3'd0);
        check_eq("mid_rst_valid", VALID, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_eq("mid_rst_fetch", MEM_ADDR, RESET_PC + 16'd1);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, ld, pp;
            logic [15:0] la;
            r  = ($urandom_range(0, 63) == 0);
            ld = ($urandom_range(0, 15) == 0);
            pp = ($urandom_range(0, 9) < 6);
            la = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                             : 16'($urandom);
            cycle(r, ld, la, pp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
